// File: rtl/vliw_pkg.sv
// Shared definitions for the VLIW forwarding/hazard unit: default geometry,
// the per-slot tracker entry type, forwarding select encoding and clog2.
// No logic, no latency, no flow control.
package vliw_pkg;

  localparam int DEF_NUM_SLOTS  = 2;
  localparam int DEF_NUM_SRC    = 2;
  localparam int DEF_REG_AW     = 3;
  localparam int DEF_DEPTH      = 3;
  localparam int DEF_LOAD_READY = 2;

  // Tracker rd field is sized for the widest register file we expect; narrower
  // register addresses are zero-extended on entry so the entry type stays fixed.
  localparam int TRK_RD_W = 8;

  // Forwarding select 0 means "take the register file value".
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                wr;  // valid instruction that writes rd
    logic                ld;  // valid instruction that is a load
    logic [TRK_RD_W-1:0] rd;
  } trk_entry_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int w = value - 1; w > 0; w = w >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/vliw_fwd_match.sv
// Priority match of one source operand against all tracked in-flight writers.
// Purely combinational, zero latency; no flow control.
// Ports: entries (stage Tk slot s at index (k-1)*NUM_SLOTS+s), rs, and the
// winning {hit, sel=k, slot=s, is_load}. Youngest stage wins, then highest slot.
module vliw_fwd_match
  import vliw_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int SEL_W     = 2,
  parameter int SLOT_W    = 1
) (
  input  trk_entry_t [DEPTH*NUM_SLOTS-1:0] entries,
  input  logic [TRK_RD_W-1:0]              rs,
  output logic                             hit,
  output logic [SEL_W-1:0]                 sel,
  output logic [SLOT_W-1:0]                slot,
  output logic                             is_load
);

  // Scan from oldest stage / lowest slot upward so that the last match seen is
  // the youngest stage and, within it, the highest slot (register-file order).
  always_comb begin
    hit     = 1'b0;
    sel     = SEL_W'(FWD_RF);
    slot    = '0;
    is_load = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (entries[(k-1)*NUM_SLOTS+s].wr && (entries[(k-1)*NUM_SLOTS+s].rd == rs)) begin
          hit     = 1'b1;
          sel     = SEL_W'(k);
          slot    = SLOT_W'(s);
          is_load = entries[(k-1)*NUM_SLOTS+s].ld;
        end
      end
    end
  end

endmodule

// File: rtl/vliw_hazard_unit.sv
// Forwarding-select and load-use hazard unit for an N-slot VLIW pipeline.
// Latency: stall/waw_conflict combinational; ex_fwd_sel/ex_fwd_slot one cycle (latched on issue).
// Backpressure: pipe_en=0 freezes all state; stall holds ID and drops a bubble into EX.
// Ports: clk/reset (sync, active-high), pipe_en, flush, ID bundle (id_*), stall,
// waw_conflict, ex_fwd_sel (0=RF, k=result reg of Tk), ex_fwd_slot.
// Optional VLIW_HAZARD_STATS_EN adds saturating stall_count and fwd_count outputs.
module vliw_hazard_unit
  import vliw_pkg::*;
#(
  parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
  parameter int NUM_SRC    = DEF_NUM_SRC,
  parameter int REG_AW     = DEF_REG_AW,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LOAD_READY = DEF_LOAD_READY,
  parameter int SEL_W      = clog2(DEPTH + 1),
  parameter int SLOT_W     = (clog2(NUM_SLOTS) > 1) ? clog2(NUM_SLOTS) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  pipe_en,
  input  logic                                  flush,
  input  logic [NUM_SLOTS-1:0]                  id_valid,
  input  logic [NUM_SLOTS-1:0]                  id_reg_write,
  input  logic [NUM_SLOTS-1:0]                  id_is_load,
  input  logic [NUM_SLOTS*REG_AW-1:0]           id_rd,
  input  logic [NUM_SLOTS*NUM_SRC*REG_AW-1:0]   id_rs,
  input  logic [NUM_SLOTS*NUM_SRC-1:0]          id_rs_used,
  output logic                                  stall,
  output logic                                  waw_conflict,
  output logic [NUM_SLOTS*NUM_SRC*SEL_W-1:0]    ex_fwd_sel,
  output logic [NUM_SLOTS*NUM_SRC*SLOT_W-1:0]   ex_fwd_slot
`ifdef VLIW_HAZARD_STATS_EN
  ,
  output logic [31:0]                           stall_count,
  output logic [31:0]                           fwd_count
`endif
);

  localparam int NUM_OPS = NUM_SLOTS * NUM_SRC;
  localparam int NUM_ENT = DEPTH * NUM_SLOTS;

  // Entry (k-1)*NUM_SLOTS+s holds stage Tk, slot s. T1 occupies the low end.
  trk_entry_t [NUM_ENT-1:0]   trk;
  trk_entry_t [NUM_SLOTS-1:0] id_ent;
  trk_entry_t [NUM_SLOTS-1:0] t1_nxt;

  logic [NUM_OPS-1:0]        op_act;
  logic [NUM_OPS-1:0]        op_hit;
  logic [NUM_OPS-1:0]        op_ld;
  logic [NUM_OPS*SEL_W-1:0]  op_sel;
  logic [NUM_OPS*SLOT_W-1:0] op_slot;
  logic [NUM_OPS*SEL_W-1:0]  sel_nxt;
  logic [NUM_OPS*SLOT_W-1:0] slot_nxt;
  logic                      load_use;
  logic                      issue;

  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      id_ent[s].wr = id_valid[s] & id_reg_write[s];
      id_ent[s].ld = id_valid[s] & id_is_load[s];
      id_ent[s].rd = TRK_RD_W'(id_rd[s*REG_AW +: REG_AW]);
    end
  end

  // The ID bundle is never a candidate: matching only looks at the tracker,
  // so slots within one bundle always see pre-bundle values.
  for (genvar op = 0; op < NUM_OPS; op++) begin : g_op
    vliw_fwd_match #(
      .NUM_SLOTS (NUM_SLOTS),
      .DEPTH     (DEPTH),
      .SEL_W     (SEL_W),
      .SLOT_W    (SLOT_W)
    ) u_match (
      .entries (trk),
      .rs      (TRK_RD_W'(id_rs[op*REG_AW +: REG_AW])),
      .hit     (op_hit[op]),
      .sel     (op_sel[op*SEL_W +: SEL_W]),
      .slot    (op_slot[op*SLOT_W +: SLOT_W]),
      .is_load (op_ld[op])
    );
    assign op_act[op] = id_valid[op / NUM_SRC] & id_rs_used[op];
  end

  // A writer in current Tk is picked up from Tk's result register once the
  // reader reaches EX, so the select equals the writer's current stage index.
  // A load is only forwardable from LOAD_READY on; anything younger stalls.
  always_comb begin
    load_use = 1'b0;
    sel_nxt  = '0;
    slot_nxt = '0;
    for (int op = 0; op < NUM_OPS; op++) begin
      if (op_act[op] && op_hit[op]) begin
        sel_nxt[op*SEL_W +: SEL_W]    = op_sel[op*SEL_W +: SEL_W];
        slot_nxt[op*SLOT_W +: SLOT_W] = op_slot[op*SLOT_W +: SLOT_W];
        if (op_ld[op] && (op_sel[op*SEL_W +: SEL_W] < SEL_W'(LOAD_READY)))
          load_use = 1'b1;
      end
    end
  end

  always_comb begin
    waw_conflict = 1'b0;
    for (int a = 0; a < NUM_SLOTS; a++)
      for (int b = a + 1; b < NUM_SLOTS; b++)
        if (id_ent[a].wr && id_ent[b].wr && (id_ent[a].rd == id_ent[b].rd))
          waw_conflict = 1'b1;
  end

  // flush kills the ID bundle, so there is nothing left to stall for.
  assign stall  = load_use & ~flush & ~reset;
  assign issue  = ~load_use & ~flush;
  assign t1_nxt = issue ? id_ent : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      trk         <= '0;
      ex_fwd_sel  <= '0;
      ex_fwd_slot <= '0;
    end else if (pipe_en) begin
      trk         <= {trk[NUM_ENT-NUM_SLOTS-1:0], t1_nxt};
      ex_fwd_sel  <= issue ? sel_nxt  : '0;
      ex_fwd_slot <= issue ? slot_nxt : '0;
    end
  end

`ifdef VLIW_HAZARD_STATS_EN
  logic [31:0] fwd_inc;
  logic [32:0] fwd_sum;

  always_comb begin
    fwd_inc = '0;
    for (int op = 0; op < NUM_OPS; op++)
      if (sel_nxt[op*SEL_W +: SEL_W] != '0) fwd_inc = fwd_inc + 32'd1;
  end

  assign fwd_sum = {1'b0, fwd_count} + {1'b0, fwd_inc};

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      fwd_count   <= '0;
    end else if (pipe_en) begin
      if (stall && (stall_count != '1)) stall_count <= stall_count + 32'd1;
      if (issue) fwd_count <= fwd_sum[32] ? '1 : fwd_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_vliw_hazard_unit.sv
// Self-checking bench for vliw_hazard_unit (default geometry: 2 slots, 2 sources,
// 8 registers, 3 tracked stages, loads forwardable from T2).
module tb_vliw_hazard_unit;

  localparam int DEPTH      = 3;
  localparam int LOAD_READY = 2;

  logic        clk = 1'b0;
  logic        reset, pipe_en, flush;
  logic [1:0]  id_valid, id_reg_write, id_is_load;
  logic [5:0]  id_rd;
  logic [11:0] id_rs;
  logic [3:0]  id_rs_used;
  logic        stall, waw_conflict;
  logic [7:0]  ex_fwd_sel;
  logic [3:0]  ex_fwd_slot;
`ifdef VLIW_HAZARD_STATS_EN
  logic [31:0] stall_count, fwd_count;
`endif

  always #5 clk = ~clk;

  vliw_hazard_unit dut (
    .clk          (clk),
    .reset        (reset),
    .pipe_en      (pipe_en),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .id_rd        (id_rd),
    .id_rs        (id_rs),
    .id_rs_used   (id_rs_used),
    .stall        (stall),
    .waw_conflict (waw_conflict),
    .ex_fwd_sel   (ex_fwd_sel),
    .ex_fwd_slot  (ex_fwd_slot)
`ifdef VLIW_HAZARD_STATS_EN
    ,
    .stall_count  (stall_count),
    .fwd_count    (fwd_count)
`endif
  );

  // ID bundle; operand op = slot*2+src, rs[op*3 +: 3], used[op].
  typedef struct packed {
    logic [1:0]  v;
    logic [1:0]  rw;
    logic [1:0]  ld;
    logic [5:0]  rd;
    logic [11:0] rs;
    logic [3:0]  used;
  } bnd_t;

  typedef struct {
    bnd_t       b;
    logic       pe, fl, rst;
    logic       e_stall, e_waw;
    logic [7:0] e_sel;
    logic [3:0] e_slot;
  } vec_t;

  // Reference model: issued bundles, youngest first.
  typedef struct packed {
    logic [1:0] wr;
    logic [1:0] ld;
    logic [5:0] rd;
  } mb_t;

  vec_t       tbl [40];
  int         nrows = 0;
  mb_t        hist [DEPTH];
  logic [7:0] m_sel;
  logic [3:0] m_slot;
  int         n_chk = 0;
  int         n_fail = 0;

  function automatic bnd_t mk(input logic [1:0] v, rw, ld, input int rd0, rd1,
                              input logic [3:0] used, input int r00, r01, r10, r11);
    bnd_t b;
    b.v    = v;
    b.rw   = rw;
    b.ld   = ld;
    b.rd   = {rd1[2:0], rd0[2:0]};
    b.rs   = {r11[2:0], r10[2:0], r01[2:0], r00[2:0]};
    b.used = used;
    return b;
  endfunction

  task automatic add_row(input bnd_t b, input logic pe, fl, rst, es, ew,
                         input logic [7:0] sel, input logic [3:0] slot);
    tbl[nrows].b       = b;
    tbl[nrows].pe      = pe;
    tbl[nrows].fl      = fl;
    tbl[nrows].rst     = rst;
    tbl[nrows].e_stall = es;
    tbl[nrows].e_waw   = ew;
    tbl[nrows].e_sel   = sel;
    tbl[nrows].e_slot  = slot;
    nrows++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge and sample outputs 1ns later.
  task automatic cyc(input bnd_t b, input logic pe, fl, rst,
                     output logic o_stall, o_waw, output logic [7:0] o_sel,
                     output logic [3:0] o_slot);
    @(negedge clk);
    id_valid     = b.v;
    id_reg_write = b.rw;
    id_is_load   = b.ld;
    id_rd        = b.rd;
    id_rs        = b.rs;
    id_rs_used   = b.used;
    pipe_en      = pe;
    flush        = fl;
    reset        = rst;
    #1;
    o_stall = stall;
    o_waw   = waw_conflict;
    o_sel   = ex_fwd_sel;
    o_slot  = ex_fwd_slot;
  endtask

  task automatic model_eval(input bnd_t b, input logic fl, rst,
                            output logic e_stall, e_waw, output logic [7:0] e_sel,
                            output logic [3:0] e_slot);
    e_stall = 1'b0;
    e_sel   = '0;
    e_slot  = '0;
    e_waw   = b.v[0] & b.v[1] & b.rw[0] & b.rw[1] & (b.rd[2:0] == b.rd[5:3]);
    for (int op = 0; op < 4; op++) begin
      bit found;
      int sel, slot;
      bit ld;
      found = 0; sel = 0; slot = 0; ld = 0;
      if (b.v[op/2] && b.used[op]) begin
        for (int age = 0; age < DEPTH; age++)
          for (int ps = 1; ps >= 0; ps--)
            if (!found && hist[age].wr[ps] && hist[age].rd[ps*3 +: 3] == b.rs[op*3 +: 3]) begin
              found = 1; sel = age + 1; slot = ps; ld = hist[age].ld[ps];
            end
      end
      if (found && ld && sel < LOAD_READY) e_stall = 1'b1;
      e_sel[op*2 +: 2] = 2'(sel);
      e_slot[op]       = (slot == 1);
    end
    if (fl || rst) e_stall = 1'b0;
  endtask

  task automatic model_clear();
    for (int a = 0; a < DEPTH; a++) hist[a] = '0;
    m_sel  = '0;
    m_slot = '0;
  endtask

  task automatic model_step(input bnd_t b, input logic pe, fl, rst, e_stall,
                            input logic [7:0] e_sel, input logic [3:0] e_slot);
    if (rst) model_clear();
    else if (pe) begin
      for (int a = DEPTH - 1; a > 0; a--) hist[a] = hist[a-1];
      if (!e_stall && !fl) begin
        hist[0].wr = b.v & b.rw;
        hist[0].ld = b.v & b.ld;
        hist[0].rd = b.rd;
        m_sel  = e_sel;
        m_slot = e_slot;
      end else begin
        hist[0] = '0;
        m_sel   = '0;
        m_slot  = '0;
      end
    end
  endtask

  initial begin
    bnd_t nop, a_w3, b_r3, l_r2, c_r2, n_w5, n1_w5, n2_r5, w_r4, r_r4;
    bnd_t l2_r6, d_r6, p_l1, q_r1, g_w0, l3_r7, f_r7, rb;
    logic s_stall, s_waw, e_stall, e_waw;
    logic [7:0] s_sel, e_sel;
    logic [3:0] s_slot, e_slot;
    int nst;

    nop   = '0;
    a_w3  = mk(2'b01, 2'b01, 2'b00, 3, 0, 4'b0000, 0, 0, 0, 0);
    b_r3  = mk(2'b01, 2'b00, 2'b00, 0, 0, 4'b0001, 3, 0, 0, 0);
    l_r2  = mk(2'b10, 2'b10, 2'b10, 0, 2, 4'b0000, 0, 0, 0, 0);
    c_r2  = mk(2'b01, 2'b00, 2'b00, 0, 0, 4'b0001, 2, 0, 0, 0);
    n_w5  = mk(2'b01, 2'b01, 2'b00, 5, 0, 4'b0000, 0, 0, 0, 0);
    n1_w5 = mk(2'b10, 2'b10, 2'b00, 0, 5, 4'b0000, 0, 0, 0, 0);
    n2_r5 = mk(2'b10, 2'b00, 2'b00, 0, 0, 4'b0100, 0, 0, 5, 0);
    w_r4  = mk(2'b11, 2'b11, 2'b00, 4, 4, 4'b0000, 0, 0, 0, 0);
    r_r4  = mk(2'b01, 2'b00, 2'b00, 0, 0, 4'b0010, 0, 4, 0, 0);
    l2_r6 = mk(2'b10, 2'b10, 2'b10, 0, 6, 4'b0000, 0, 0, 0, 0);
    d_r6  = mk(2'b01, 2'b00, 2'b00, 0, 0, 4'b0001, 6, 0, 0, 0);
    p_l1  = mk(2'b01, 2'b01, 2'b01, 1, 0, 4'b0000, 0, 0, 0, 0);
    q_r1  = mk(2'b10, 2'b00, 2'b00, 0, 0, 4'b0100, 0, 0, 1, 0);
    g_w0  = mk(2'b01, 2'b01, 2'b00, 0, 0, 4'b0000, 0, 0, 0, 0);
    l3_r7 = mk(2'b11, 2'b10, 2'b10, 0, 7, 4'b0001, 0, 0, 0, 0);
    f_r7  = mk(2'b01, 2'b00, 2'b00, 0, 0, 4'b0001, 7, 0, 0, 0);

    //       bundle  pe    fl    rst   stall waw  ex_sel  ex_slot (seen this cycle)
    add_row(nop,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);  // reset state
    add_row(a_w3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
    add_row(b_r3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
    add_row(nop,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 4'h0);  // r3 from T1 slot0
    add_row(l_r2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
    add_row(c_r2,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0);  // load-use
    add_row(c_r2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);  // bubble in EX
    add_row(nop,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 4'h1);  // r2 from T2 slot1
    add_row(n_w5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
    add_row(n1_w5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
    add_row(n2_r5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
    add_row(nop,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 4'h4);  // youngest wins
    add_row(w_r4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'h0);  // same-bundle WAW
    add_row(nop,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
    add_row(r_r4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
    add_row(nop,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h08, 4'h2);  // higher slot wins
    add_row(l2_r6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
    add_row(d_r6,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);  // flush beats stall
    add_row(d_r6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);  // flushed: nothing latched
    add_row(p_l1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 4'h1);  // hold x3
    add_row(p_l1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 4'h1);
    add_row(p_l1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 4'h1);
    add_row(p_l1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 4'h1);
    add_row(q_r1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0);  // stall held while frozen
    add_row(q_r1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0);
    add_row(q_r1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0);
    add_row(q_r1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
    add_row(g_w0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 4'h0);
    add_row(l3_r7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);  // r0 is ordinary
    add_row(f_r7,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 4'h0);
    add_row(f_r7,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 4'h0);  // reset mid-stall
    add_row(f_r7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
    add_row(nop,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);

    // Initial reset, unchecked (outputs undefined before the first edge).
    cyc(nop, 1'b1, 1'b0, 1'b1, s_stall, s_waw, s_sel, s_slot);
    cyc(nop, 1'b1, 1'b0, 1'b1, s_stall, s_waw, s_sel, s_slot);

    for (int i = 0; i < nrows; i++) begin
      cyc(tbl[i].b, tbl[i].pe, tbl[i].fl, tbl[i].rst, s_stall, s_waw, s_sel, s_slot);
      chk($sformatf("row%0d stall", i), 32'(s_stall), 32'(tbl[i].e_stall));
      chk($sformatf("row%0d waw", i),   32'(s_waw),   32'(tbl[i].e_waw));
      chk($sformatf("row%0d ex_fwd_sel", i),  32'(s_sel),  32'(tbl[i].e_sel));
      chk($sformatf("row%0d ex_fwd_slot", i), 32'(s_slot), 32'(tbl[i].e_slot));
    end

    // Load then dependent reader held in ID until the stall clears (bounded).
    cyc(l_r2, 1'b1, 1'b0, 1'b0, s_stall, s_waw, s_sel, s_slot);
    nst = 0;
    for (int t = 0; t < 6; t++) begin
      cyc(c_r2, 1'b1, 1'b0, 1'b0, s_stall, s_waw, s_sel, s_slot);
      if (!s_stall) break;
      nst++;
    end
    chk("load-use stall length", 32'(nst), 32'd1);
    cyc(nop, 1'b1, 1'b0, 1'b0, s_stall, s_waw, s_sel, s_slot);
    chk("post-stall ex_fwd_sel", 32'(s_sel), 32'h02);
    chk("post-stall ex_fwd_slot", 32'(s_slot), 32'h1);

    // Randomized traffic against the reference model.
    cyc(nop, 1'b1, 1'b0, 1'b1, s_stall, s_waw, s_sel, s_slot);
    model_clear();
    for (int i = 0; i < 600; i++) begin
      logic pe, fl, rst;
      rb = mk(2'($urandom), 2'($urandom), 2'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 4'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      pe  = ($urandom_range(0, 9) != 0);
      fl  = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 49) == 0);
      cyc(rb, pe, fl, rst, s_stall, s_waw, s_sel, s_slot);
      model_eval(rb, fl, rst, e_stall, e_waw, e_sel, e_slot);
      chk($sformatf("rnd%0d stall", i), 32'(s_stall), 32'(e_stall));
      chk($sformatf("rnd%0d waw", i),   32'(s_waw),   32'(e_waw));
      chk($sformatf("rnd%0d ex_fwd_sel", i),  32'(s_sel),  32'(m_sel));
      chk($sformatf("rnd%0d ex_fwd_slot", i), 32'(s_slot), 32'(m_slot));
      model_step(rb, pe, fl, rst, e_stall, e_sel, e_slot);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
